config_load_ctrl: RTL and testbench

CONFIG_LOAD_CTRL -- requirements
Module: config_load_ctrl

---
 rtl/config_load_ctrl.sv | 112 +++++++++++
 tb/tb_config_load_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | config_load_ctrl: sequences checksummed words into a one-hot latch array |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module config_load_ctrl #(
  parameter  int NUM_WORDS = 44,
  parameter  int WORD_W    = 32,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic [IDX_W-1:0]     io_word_idx,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0]     c_last_idx = IDX_W'(NUM_WORDS - 1);
  localparam logic [NUM_WORDS-1:0] c_one      = NUM_WORDS'(1);

  state_t                 r_state;
  state_t                 w_next;
  logic [WORD_W-1:0]      r_d_out;
  logic [WORD_W-1:0]      r_acc;
  logic [NUM_WORDS-1:0]   r_en;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_done;
  logic                   w_ready;
  logic                   w_start_ok;
  logic                   w_load;
  logic                   w_advance;
  logic [NUM_WORDS-1:0]   w_onehot;

  assign w_ready    = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign w_onehot   = c_one << r_idx;
  assign w_start_ok = !io_abort && io_start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_load     = !io_abort && (r_state == S_WAIT) && io_in_valid;
  assign w_advance  = !io_abort && (r_state == S_HOLD) && (r_idx < c_last_idx);

  always_comb begin
    w_next = r_state;
    if (io_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (io_start) w_next = S_WAIT;
        S_WAIT:   if (io_in_valid) w_next = S_STROBE;
        S_STROBE: w_next = S_HOLD;
        S_HOLD:   w_next = (r_idx < c_last_idx) ? S_WAIT : S_CHECK;
        S_CHECK:  if (io_in_valid) w_next = (io_in_bits == r_acc) ? S_DONE : S_ERR;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Enables are registered so they are glitch-free and high only while in STROBE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_d_out <= '0;
      r_acc   <= '0;
      r_en    <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en    <= (w_next == S_STROBE) ? w_onehot : '0;
      r_done  <= (r_state == S_CHECK) && (w_next == S_DONE);
      if (w_start_ok) begin
        r_idx <= '0;
        r_acc <= '0;
      end
      if (w_load) begin
        r_d_out <= io_in_bits;
        r_acc   <= r_acc ^ io_in_bits;
      end
      if (w_advance) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign io_in_ready   = w_ready;
  assign io_d_out      = r_d_out;
  assign io_configs_en = r_en;
  assign io_word_idx   = r_idx;
  assign io_busy       = (r_state == S_WAIT) || (r_state == S_STROBE) ||
                         (r_state == S_HOLD) || (r_state == S_CHECK);
  assign io_done       = r_done;
  assign io_error      = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_config_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_config_load_ctrl: directed vector table plus multi-cycle sequences    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_config_load_ctrl;

  localparam int NW = 44;
  localparam int WW = 32;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          io_start = 1'b0;
  logic          io_abort = 1'b0;
  logic          io_in_valid = 1'b0;
  logic [WW-1:0] io_in_bits = '0;
  logic          io_in_ready;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic [IW-1:0] io_word_idx;
  logic          io_busy;
  logic          io_done;
  logic          io_error;

  config_load_ctrl #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_word_idx   (io_word_idx),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_error      (io_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] oh(input int i);
    logic [NW-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // One word: handshake -> STROBE -> HOLD -> next state; source keeps valid high.
  task automatic feed_word(input int i, input logic [WW-1:0] nxt, input bit spam);
    io_in_valid = 1'b1;
    io_in_bits  = WW'(i + 1);
    tick;
    chk($sformatf("w%0d.strobe_en", i), 64'(io_configs_en), 64'(oh(i)));
    chk($sformatf("w%0d.strobe_dout", i), 64'(io_d_out), 64'(i + 1));
    chk($sformatf("w%0d.strobe_idx", i), 64'(io_word_idx), 64'(i));
    io_in_bits = nxt;
    if (spam) io_start = 1'b1;
    tick;
    io_start = 1'b0;
    chk($sformatf("w%0d.hold_en", i), 64'(io_configs_en), 64'(0));
    chk($sformatf("w%0d.hold_dout", i), 64'(io_d_out), 64'(i + 1));
    if (spam) begin
      chk("spam.idx", 64'(io_word_idx), 64'(i));
      chk("spam.busy", 64'(io_busy), 64'(1));
    end
    tick;
  endtask

  task automatic do_load(input logic [WW-1:0] csum, input int stall_word,
                         input int spam_word, input bit exp_ok, input bit timing);
    int c0;
    io_in_valid = 1'b0;
    io_start    = 1'b1;
    tick;
    io_start = 1'b0;
    chk("start.ready", 64'(io_in_ready), 64'(1));
    chk("start.idx", 64'(io_word_idx), 64'(0));
    c0 = cyc;
    for (int i = 0; i < NW; i++) begin
      if (i == stall_word) begin
        io_in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick;
          chk("stall.en", 64'(io_configs_en), 64'(0));
          chk("stall.idx", 64'(io_word_idx), 64'(stall_word));
        end
      end
      feed_word(i, (i == NW - 1) ? csum : WW'(i + 2), i == spam_word);
      if (i < NW - 1) begin
        chk($sformatf("w%0d.next_idx", i), 64'(io_word_idx), 64'(i + 1));
        chk($sformatf("w%0d.next_ready", i), 64'(io_in_ready), 64'(1));
      end else begin
        chk("check.ready", 64'(io_in_ready), 64'(1));
        chk("check.busy", 64'(io_busy), 64'(1));
        chk("check.idx", 64'(io_word_idx), 64'(NW - 1));
        if (timing) chk("check.latency", 64'(cyc - c0), 64'(132));
      end
    end
    tick;
    io_in_valid = 1'b0;
    chk("end.done", 64'(io_done), 64'(exp_ok));
    chk("end.error", 64'(io_error), 64'(!exp_ok));
    chk("end.busy", 64'(io_busy), 64'(0));
    repeat (3) tick;
    chk("hold.done", 64'(io_done), 64'(0));
    chk("hold.error", 64'(io_error), 64'(!exp_ok));
    chk("hold.en", 64'(io_configs_en), 64'(0));
  endtask

  typedef struct {
    logic        start;
    logic        abort;
    logic        valid;
    logic [31:0] bits;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    int          idx;
    int          en;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 32'h11};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1, 32'h11};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1, 32'h11};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1, 32'h11};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1, 32'h22};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 32'h22};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 32'h22};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 32'h22};

    repeat (2) tick;
    chk("rst.en", 64'(io_configs_en), 64'(0));
    chk("rst.ready", 64'(io_in_ready), 64'(0));
    chk("rst.busy", 64'(io_busy), 64'(0));
    chk("rst.dout", 64'(io_d_out), 64'(0));
    reset = 1'b1;

    for (int k = 0; k < 12; k++) begin
      io_start    = tbl[k].start;
      io_abort    = tbl[k].abort;
      io_in_valid = tbl[k].valid;
      io_in_bits  = tbl[k].bits;
      tick;
      chk($sformatf("v%0d.ready", k), 64'(io_in_ready), 64'(tbl[k].ready));
      chk($sformatf("v%0d.busy", k), 64'(io_busy), 64'(tbl[k].busy));
      chk($sformatf("v%0d.done", k), 64'(io_done), 64'(tbl[k].done));
      chk($sformatf("v%0d.error", k), 64'(io_error), 64'(tbl[k].err));
      chk($sformatf("v%0d.idx", k), 64'(io_word_idx), 64'(tbl[k].idx));
      chk($sformatf("v%0d.en", k), 64'(io_configs_en), 64'(oh(tbl[k].en)));
      chk($sformatf("v%0d.dout", k), 64'(io_d_out), 64'(tbl[k].dout));
    end
    io_start = 1'b0; io_abort = 1'b0; io_in_valid = 1'b0; io_in_bits = '0;

    do_load(32'h0000002C, -1, -1, 1'b1, 1'b1);
    do_load(32'h00000000, -1, -1, 1'b0, 1'b0);
    do_load(32'h0000002C, 10, 5, 1'b1, 1'b0);

    // Abort while word 20 is strobing.
    io_start = 1'b1;
    tick;
    io_start = 1'b0;
    for (int i = 0; i < 20; i++) feed_word(i, WW'(i + 2), 1'b0);
    io_in_valid = 1'b1;
    io_in_bits  = 32'd21;
    tick;
    chk("abort.pre_en", 64'(io_configs_en), 64'(oh(20)));
    io_in_valid = 1'b0;
    io_abort    = 1'b1;
    tick;
    io_abort = 1'b0;
    chk("abort.en", 64'(io_configs_en), 64'(0));
    chk("abort.busy", 64'(io_busy), 64'(0));
    chk("abort.ready", 64'(io_in_ready), 64'(0));
    io_start = 1'b1;
    tick;
    io_start = 1'b0;
    chk("abort.restart_idx", 64'(io_word_idx), 64'(0));

    // Asynchronous reset between edges while in HOLD.
    io_in_valid = 1'b1;
    io_in_bits  = 32'h55;
    tick;
    io_in_valid = 1'b0;
    tick;
    chk("arst.pre_dout", 64'(io_d_out), 64'h55);
    #2 reset = 1'b0;
    #1;
    chk("arst.dout", 64'(io_d_out), 64'(0));
    chk("arst.en", 64'(io_configs_en), 64'(0));
    chk("arst.idx", 64'(io_word_idx), 64'(0));
    chk("arst.ready", 64'(io_in_ready), 64'(0));
    chk("arst.busy", 64'(io_busy), 64'(0));
    chk("arst.done", 64'(io_done), 64'(0));
    chk("arst.error", 64'(io_error), 64'(0));
    #1 reset = 1'b1;
    io_in_valid = 1'b1;
    io_in_bits  = 32'h77;
    repeat (2) tick;
    chk("post_rst.ready", 64'(io_in_ready), 64'(0));
    chk("post_rst.dout", 64'(io_d_out), 64'(0));
    io_in_valid = 1'b0;
    io_start    = 1'b1;
    tick;
    io_start = 1'b0;
    chk("post_rst.start_ready", 64'(io_in_ready), 64'(1));

    // Asynchronous reset while an enable is high.
    io_in_valid = 1'b1;
    io_in_bits  = 32'h66;
    tick;
    io_in_valid = 1'b0;
    chk("arst_strobe.pre_en", 64'(io_configs_en), 64'(oh(0)));
    #2 reset = 1'b0;
    #1;
    chk("arst_strobe.en", 64'(io_configs_en), 64'(0));
    #1 reset = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
